// File: rtl/mem_row_reader_pkg.sv
// Shared types and width helpers for the row reader.
// State encoding, lane read latency, counter width functions.
package mem_row_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Fixed read latency of the BRAM lane
   localparam int READ_LAT = 2;

   // Index width for n entries, never below 1 bit
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Width able to hold the value n itself
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/mem_row_reader_pix_fifo.sv
// Register-based first-word-fall-through FIFO with occupancy count.
// Ports: clk, rst_n, push/din, pop/dout, valid (non-empty), count.
module pix_fifo
   import mem_row_reader_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic [DW-1:0]           din,
   input  logic                    pop,
   output logic [DW-1:0]           dout,
   output logic                    valid,
   output logic [cnt_w(DEPTH)-1:0] count
);

   localparam int PW = idx_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Depth need not be a power of two, so pointers wrap explicitly
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= nxt(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= nxt(rd_ptr);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign dout  = mem[rd_ptr];
   assign valid = (count != '0);

endmodule

// File: rtl/mem_row_reader.sv
// Row scan reader: issues lane reads for one row, streams pixels out.
// Ports: clk, rst_n, start/row in, busy/done out, mem_addr/mem_dout
// lane side, pix_data/pix_valid/pix_ready/pix_last stream side.
// Build option MEM_ROW_READER_TESTPAT_EN: pixels = col ^ row.
module mem_row_reader
   import mem_row_reader_pkg::*;
#(
   parameter int ADDR_BITS  = 11,
   parameter int DW         = 8,
   parameter int COLS       = 64,
   parameter int ROW_BITS   = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ROW_BITS-1:0]  row,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_BITS-1:0] mem_addr,
   input  logic [DW-1:0]        mem_dout,
   output logic [DW-1:0]        pix_data,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic                 pix_last
);

   localparam int COL_W = idx_w(COLS);
   localparam int CNT_W = cnt_w(FIFO_DEPTH);

   state_t state, state_n;

   logic [COL_W-1:0]    col;
   logic [READ_LAT-1:0] pv;
   logic [READ_LAT-1:0] pl;
   logic [CNT_W-1:0]    fcnt;
   logic [CNT_W:0]      occ;
   logic [DW:0]         fhead;
   logic [DW-1:0]       push_d;
   logic                fvalid;
   logic                pop;
   logic                credit;
   logic                issue;
   logic                load;
   logic                last_col;
   logic                fin;

`ifdef MEM_ROW_READER_TESTPAT_EN
   logic [ROW_BITS-1:0] row_q;
   logic [DW-1:0]       pc [READ_LAT];
`endif

   assign pop      = fvalid && pix_ready;
   assign last_col = (col == COL_W'(COLS - 1));

   // Slots already promised: reads in the pipe plus FIFO entries
   always_comb begin
      occ = (CNT_W+1)'(fcnt);
      for (int i = 0; i < READ_LAT; i++) begin
         occ = occ + (CNT_W+1)'(pv[i]);
      end
   end

   // A pop this cycle frees a slot for a read issued now
   assign credit = (occ - (CNT_W+1)'(pop)) < (CNT_W+1)'(FIFO_DEPTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      issue   = 1'b0;
      load    = 1'b0;
      fin     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            if (credit) begin
               issue = 1'b1;
               if (last_col) state_n = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && pix_last) begin
               fin     = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // mem_addr always holds the next address to read, so an issue
   // presents it in the same cycle the decision is made.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col      <= '0;
         mem_addr <= '0;
         pv       <= '0;
         pl       <= '0;
         done     <= 1'b0;
      end else begin
         done <= fin;
         pv   <= {pv[READ_LAT-2:0], issue};
         pl   <= {pl[READ_LAT-2:0], issue && last_col};
         if (load) begin
            col      <= '0;
            mem_addr <= ADDR_BITS'(32'(row) * COLS);
         end else if (issue && !last_col) begin
            col      <= col + COL_W'(1);
            mem_addr <= mem_addr + ADDR_BITS'(1);
         end
      end
   end

`ifdef MEM_ROW_READER_TESTPAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q <= '0;
         for (int i = 0; i < READ_LAT; i++) pc[i] <= '0;
      end else begin
         if (load) row_q <= row;
         pc[0] <= DW'(col);
         for (int i = 1; i < READ_LAT; i++) pc[i] <= pc[i-1];
      end
   end

   assign push_d = pc[READ_LAT-1] ^ DW'(row_q);
`else
   assign push_d = mem_dout;
`endif

   pix_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (DW + 1)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (pv[READ_LAT-1]),
      .din   ({pl[READ_LAT-1], push_d}),
      .pop   (pop),
      .dout  (fhead),
      .valid (fvalid),
      .count (fcnt)
   );

   assign busy      = (state != IDLE);
   assign pix_valid = fvalid;
   assign pix_last  = fvalid ? fhead[DW]     : 1'b0;
   assign pix_data  = fvalid ? fhead[DW-1:0] : '0;

endmodule

// File: tb/tb_mem_row_reader.sv
// Directed bench for mem_row_reader with a 2-cycle lane model.
// Scoreboard queue of expected beats, checked on each handshake.
module tb_mem_row_reader;

   localparam int ADDR_BITS  = 11;
   localparam int DW         = 8;
   localparam int COLS       = 64;
   localparam int ROW_BITS   = 5;
   localparam int FIFO_DEPTH = 4;
   localparam int LANE_N     = 1 << ADDR_BITS;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic [ROW_BITS-1:0]  row = '0;
   logic                 busy;
   logic                 done;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [DW-1:0]        mem_dout = '0;
   logic [DW-1:0]        pix_data;
   logic                 pix_valid;
   logic                 pix_ready = 1'b1;
   logic                 pix_last;

   logic [DW-1:0] lane_mem [LANE_N];
   logic [DW-1:0] lane_q1 = '0;
   logic [DW:0]   exp_q [$];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Lane: address sampled at one edge, data visible after the next
   always @(posedge clk) begin
      lane_q1  <= lane_mem[mem_addr];
      mem_dout <= lane_q1;
   end

   mem_row_reader #(
      .ADDR_BITS  (ADDR_BITS),
      .DW         (DW),
      .COLS       (COLS),
      .ROW_BITS   (ROW_BITS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .row       (row),
      .busy      (busy),
      .done      (done),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .pix_data  (pix_data),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_last  (pix_last)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_pix(input int r, input int k);
`ifdef MEM_ROW_READER_TESTPAT_EN
      logic [DW-1:0] kk;
      logic [DW-1:0] rr;
      kk = DW'(k);
      rr = DW'(r);
      return kk ^ rr;
`else
      return lane_mem[(r * COLS + k) % LANE_N];
`endif
   endfunction

   // One row request; abort_at >= 0 resets the DUT at that beat,
   // dup_at >= 0 pulses start (row 9) at that cycle while busy.
   task automatic run_row(input int r, input bit rnd, input bit chk_a,
                          input int abort_at, input int dup_at);
      int          c;
      int          beat;
      int          base;
      bit          seen_v;
      bit          fin;
      bit          pv;
      bit          pr;
      logic [DW:0] pd;
      logic [DW:0] e;
      base   = (r * COLS) % LANE_N;
      seen_v = 1'b0;
      fin    = 1'b0;
      pv     = 1'b0;
      pr     = 1'b0;
      pd     = '0;
      for (int k = 0; k < COLS; k++) begin
         exp_q.push_back({(k == COLS - 1), exp_pix(r, k)});
      end
      @(negedge clk);
      row   = ROW_BITS'(r);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_on", 32'(busy), 1);
      c    = 0;
      beat = 0;
      while (!fin) begin
         if (c > 2000) begin
            chk("timeout", 0, 1);
            break;
         end
         if (c == dup_at) begin
            row   = 5'd9;
            start = 1'b1;
         end else if (c == dup_at + 1) begin
            start = 1'b0;
         end
         if (abort_at >= 0 && beat == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_busy", 32'(busy), 0);
            chk("rst_valid", 32'(pix_valid), 0);
            chk("rst_data", 32'({pix_last, pix_data}), 0);
            chk("rst_addr", 32'(mem_addr), 0);
            exp_q.delete();
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               chk("rst_no_done", 32'(done), 0);
            end
            return;
         end
         pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (chk_a && c < COLS) begin
            chk("addr", 32'(mem_addr), (base + c) % LANE_N);
         end
         if (pix_valid && !seen_v) begin
            seen_v = 1'b1;
            if (!rnd) chk("first_valid_lat", c, 3);
         end
         if (pv && !pr) begin
            chk("stall_valid", 32'(pix_valid), 1);
            chk("stall_data", 32'({pix_last, pix_data}), 32'(pd));
         end
         if (rnd) begin
            chk("credit", 32'(dut.occ <= FIFO_DEPTH), 1);
         end
         if (done) begin
            chk("done_beats", beat, COLS);
            chk("done_busy", 32'(busy), 0);
            fin = 1'b1;
         end else if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("pixel", 32'({pix_last, pix_data}), 32'(e));
            end
            beat++;
         end
         pv = pix_valid;
         pr = pix_ready;
         pd = {pix_last, pix_data};
         @(negedge clk);
         c++;
      end
      if (fin) chk("done_pulse", 32'(done), 0);
      pix_ready = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < LANE_N; i++) begin
         lane_mem[i] = DW'((i * 37 + (i >> 5)) ^ 8'h5A);
      end
      #1;
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_valid", 32'(pix_valid), 0);
      chk("reset_last", 32'(pix_last), 0);
      chk("reset_data", 32'(pix_data), 0);
      chk("reset_addr", 32'(mem_addr), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_row(3, 1'b0, 1'b1, -1, -1);
      run_row(7, 1'b1, 1'b0, -1, 10);
      run_row(31, 1'b0, 1'b1, -1, -1);
      run_row(12, 1'b0, 1'b0, 20, -1);
      run_row(0, 1'b0, 1'b1, -1, -1);
`ifdef MEM_ROW_READER_TESTPAT_EN
      for (int i = 0; i < LANE_N; i++) lane_mem[i] = 8'hC3;
      run_row(5, 1'b0, 1'b1, -1, -1);
`endif
      chk("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
